spi_lcd_receiver: RTL and testbench
===================================

Name: spi_lcd_receiver

Overview:
Synthesizable SPI mode-0 peripheral: the receive end of the link driven by spi_controller (spi_clk, spi_mosi, spi_cs_n, lcd_dc). It oversamples the serial pins in the system clock domain, deserializes MSB-first bytes, tags each byte with its lcd_dc level, and buffers byte+dc pairs in a small FIFO behind a valid/ready port. It is used as an LCD-side stand-in for loopback and self-check of the SPI controller on the FPGA.

Parameters:
FIFO_DEPTH, 4, entries of {dc, byte}; power of 2, minimum 2
SYNC_STAGES, 2, synchronizer flops per serial input; minimum 2

Ports:
clk  input  1  system clock; spi_clk must be at most clk/4
reset  input  1  synchronous reset, active-high
spi_clk  input  1  serial clock from the controller; idles low
spi_mosi  input  1  serial data, MSB first
spi_cs_n  input  1  chip select, active-low
lcd_dc  input  1  data/command flag (0 = command, 1 = data)
rx_data  output  8  byte at FIFO head
rx_dc  output  1  lcd_dc tag of the FIFO head
rx_valid  output  1  FIFO not empty
rx_ready  input  1  consumer pop; pops when rx_valid && rx_ready
rx_overrun  output  1  sticky: a completed byte was dropped because the FIFO was full
overrun_clear  input  1  clears rx_overrun
rx_abort  output  1  one-clk pulse: cs_n deasserted with a partial byte in progress
busy  output  1  receiver in SHIFT state

Behaviour:
- Reset: all outputs 0, FIFO empty, bit_cnt=0, state WAIT_DESEL.
- All four serial inputs pass through SYNC_STAGES flops. Edges are detected on the synchronized spi_clk against a one-cycle-delayed copy.
- FSM:
  - WAIT_DESEL: stay until synced cs_n=1, then go to IDLE. This prevents misaligned bytes when reset releases mid-frame.
  - IDLE: synced cs_n=0 moves to SHIFT with bit_cnt=0.
  - SHIFT: on each synced spi_clk rising edge, shift = {shift[6:0], mosi_sync} and increment bit_cnt (3-bit, wraps 7 to 0).
    - On the edge where bit_cnt==7, the completed byte and synced lcd_dc are pushed next cycle, and bit_cnt wraps to 0. Multi-byte frames need no cs_n toggle.
    - Synced cs_n=1 moves to IDLE. If bit_cnt!=0, pulse rx_abort for 1 clk and discard the partial byte.
    - spi_clk edges while cs_n=1 are ignored.
- Latency: rx_valid rises at most SYNC_STAGES+2 clk after the 8th spi_clk rising edge at the pin.
- FIFO:
  - Write and read pointers are log2(FIFO_DEPTH)+1 bits, with MSB full/empty comparison.
  - rx_data and rx_dc are registered and show the head entry whenever rx_valid=1. They are 0 when empty.
  - Pop and push in the same cycle:
    - When full, the push is accepted and occupancy is unchanged.
    - When empty, the push is accepted and rx_valid=1 next cycle.
  - Push while full with no pop: byte dropped, rx_overrun set, FIFO contents unchanged.
  - rx_ready while empty: no effect.
  - overrun_clear and a new overrun in the same cycle: set wins.
- busy=1 exactly while in SHIFT.
- Reset asserted mid-byte: state returns to WAIT_DESEL, the FIFO is flushed, and rx_overrun is cleared.

Optional Feature:
SPI_RX_ECHO_EN:
- When defined, adds output spi_miso (1 bit).
- spi_miso shifts out the previous completed byte, MSB first. It is updated on each synced spi_clk falling edge while in SHIFT, so the controller samples it on the rising edge.
- The first byte of a frame echoes the last byte of the previous frame, or 0x00 after reset.
- spi_miso=0 while cs_n=1.
- When undefined, the port and logic are absent and behaviour is otherwise identical.

Test Plan:
- clk=100 MHz, spi_clk=12.5 MHz, dc=0, send 0xA5, rx_ready=1 -> rx_valid within 4 clk of the 8th edge; rx_data=0xA5, rx_dc=0; pops once; rx_abort never pulses.
- One cs_n frame: 0x2C with dc=0, then 0x12, 0x34 with dc=1, rx_ready=0 -> FIFO holds {0,2C},{1,12},{1,34}; draining yields that order; then rx_valid=0.
- rx_ready=0, send 0x01..0x05 -> 0x01..0x04 retained, rx_overrun=1; overrun_clear -> 0; then pop while 0x06 completes -> accepted, no overrun.
- 3 bits (101), then cs_n high -> rx_abort single pulse, no push; next frame 0x3C -> rx_data=0x3C.
- Assert reset after 4 bits with cs_n low, release with cs_n still low, finish the byte -> no push. After cs_n toggles high then low, 0x7E is received correctly.
- With SPI_RX_ECHO_EN: send 0x5A, then 0xC3 in the next frame -> spi_miso bits sampled on rising edges during the second byte = 0x5A.

Source files
------------

// File: rtl/spi_lcd_receiver.sv
`default_nettype none
// ============================================================================
// Module   : spi_lcd_receiver
// Brief    : SPI mode-0 receive end for the LCD link. Oversamples the serial
//            pins, deserializes MSB-first bytes tagged with lcd_dc and queues
//            them in a small FIFO behind a valid/ready port.
//            Optional MISO echo of the previous byte: define SPI_RX_ECHO_EN.
// Revision : 1.0 - initial release
// ============================================================================
module spi_lcd_receiver #(
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       spi_clk,
    input  logic       spi_mosi,
    input  logic       spi_cs_n,
    input  logic       lcd_dc,
    output logic [7:0] rx_data,
    output logic       rx_dc,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       rx_overrun,
    input  logic       overrun_clear,
    output logic       rx_abort,
`ifdef SPI_RX_ECHO_EN
    output logic       spi_miso,
`endif
    output logic       busy
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_WAIT_DESEL = 2'd0,
        S_IDLE       = 2'd1,
        S_SHIFT      = 2'd2
    } state_t;

    // Bit order in each stage: {spi_clk, mosi, cs_n, dc}
    logic [3:0] r_sync [SYNC_STAGES];
    logic       r_sck_d;
    logic       w_sck_s, w_mosi_s, w_cs_s, w_dc_s, w_sck_rise;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
            r_sck_d <= 1'b0;
        end else begin
            r_sync[0] <= {spi_clk, spi_mosi, spi_cs_n, lcd_dc};
            for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
            r_sck_d <= w_sck_s;
        end
    end

    assign {w_sck_s, w_mosi_s, w_cs_s, w_dc_s} = r_sync[SYNC_STAGES-1];
    assign w_sck_rise = w_sck_s & ~r_sck_d;

    state_t     r_state, w_state_nxt;
    logic [2:0] r_bit_cnt, w_bit_cnt_nxt;
    logic [7:0] r_shift;
    logic       w_shift_en, w_abort_nxt, w_push_nxt;
    logic       r_abort, r_push;
    logic [8:0] r_push_data;

    always_comb begin
        w_state_nxt   = r_state;
        w_bit_cnt_nxt = r_bit_cnt;
        w_shift_en    = 1'b0;
        w_abort_nxt   = 1'b0;
        w_push_nxt    = 1'b0;
        case (r_state)
            S_WAIT_DESEL: if (w_cs_s) w_state_nxt = S_IDLE;
            S_IDLE: begin
                if (!w_cs_s) begin
                    w_state_nxt   = S_SHIFT;
                    w_bit_cnt_nxt = 3'd0;
                end
            end
            S_SHIFT: begin
                if (w_cs_s) begin
                    w_state_nxt   = S_IDLE;
                    w_abort_nxt   = (r_bit_cnt != 3'd0);
                    w_bit_cnt_nxt = 3'd0;
                end else if (w_sck_rise) begin
                    w_shift_en    = 1'b1;
                    w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                    w_push_nxt    = (r_bit_cnt == 3'd7);
                end
            end
            default: w_state_nxt = S_WAIT_DESEL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_WAIT_DESEL;
            r_bit_cnt   <= 3'd0;
            r_shift     <= 8'd0;
            r_abort     <= 1'b0;
            r_push      <= 1'b0;
            r_push_data <= 9'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_abort   <= w_abort_nxt;
            r_push    <= w_push_nxt;
            if (w_shift_en) r_shift <= {r_shift[6:0], w_mosi_s};
            if (w_push_nxt) r_push_data <= {w_dc_s, r_shift[6:0], w_mosi_s};
        end
    end

    // FIFO with one extra pointer bit to separate full from empty
    logic [8:0]  r_mem [FIFO_DEPTH];
    logic [AW:0] r_wr_ptr, r_rd_ptr, w_wr_ptr_nxt, w_rd_ptr_nxt;
    logic        w_empty, w_full, w_pop, w_wr, w_ovf, w_empty_nxt;
    logic [8:0]  w_head_nxt;
    logic        r_rx_valid, r_rx_dc, r_overrun;
    logic [7:0]  r_rx_data;

    assign w_empty      = (r_wr_ptr == r_rd_ptr);
    assign w_full       = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                          (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop        = !w_empty && rx_ready;
    assign w_wr         = r_push && (!w_full || w_pop);
    assign w_ovf        = r_push && w_full && !w_pop;
    assign w_wr_ptr_nxt = r_wr_ptr + (AW+1)'(w_wr);
    assign w_rd_ptr_nxt = r_rd_ptr + (AW+1)'(w_pop);
    assign w_empty_nxt  = (w_wr_ptr_nxt == w_rd_ptr_nxt);
    // Next head may be the entry written this very cycle
    assign w_head_nxt   = (w_wr && (r_wr_ptr[AW-1:0] == w_rd_ptr_nxt[AW-1:0]))
                          ? r_push_data : r_mem[w_rd_ptr_nxt[AW-1:0]];

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr[AW-1:0]] <= r_push_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_rx_valid <= 1'b0;
            r_rx_dc    <= 1'b0;
            r_rx_data  <= 8'd0;
            r_overrun  <= 1'b0;
        end else begin
            r_wr_ptr   <= w_wr_ptr_nxt;
            r_rd_ptr   <= w_rd_ptr_nxt;
            r_rx_valid <= !w_empty_nxt;
            {r_rx_dc, r_rx_data} <= w_empty_nxt ? 9'd0 : w_head_nxt;
            if (w_ovf)              r_overrun <= 1'b1;
            else if (overrun_clear) r_overrun <= 1'b0;
        end
    end

    assign rx_data    = r_rx_data;
    assign rx_dc      = r_rx_dc;
    assign rx_valid   = r_rx_valid;
    assign rx_overrun = r_overrun;
    assign rx_abort   = r_abort;
    assign busy       = (r_state == S_SHIFT);

`ifdef SPI_RX_ECHO_EN
    logic [7:0] r_last_byte, r_miso_shift;
    logic       w_sck_fall;

    assign w_sck_fall = ~w_sck_s & r_sck_d;

    // A falling edge with bit_cnt==0 can only follow a completed byte
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_byte  <= 8'd0;
            r_miso_shift <= 8'd0;
        end else begin
            if (w_push_nxt) r_last_byte <= {r_shift[6:0], w_mosi_s};
            if (r_state == S_IDLE && w_state_nxt == S_SHIFT)
                r_miso_shift <= r_last_byte;
            else if (r_state == S_SHIFT && !w_cs_s && w_sck_fall)
                r_miso_shift <= (r_bit_cnt == 3'd0) ? r_last_byte
                                                    : {r_miso_shift[6:0], 1'b0};
        end
    end

    assign spi_miso = (r_state == S_SHIFT) && r_miso_shift[7];
`endif

endmodule
`default_nettype wire

// File: tb/tb_spi_lcd_receiver.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_lcd_receiver
// Brief    : Scoreboard bench for spi_lcd_receiver with randomized frames.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_lcd_receiver;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset = 1'b1, spi_clk = 1'b0, spi_mosi = 1'b0, spi_cs_n = 1'b1;
    logic lcd_dc = 1'b0, rx_ready = 1'b0, overrun_clear = 1'b0;
    logic [7:0] rx_data;
    logic rx_dc, rx_valid, rx_overrun, rx_abort, busy;
`ifdef SPI_RX_ECHO_EN
    logic spi_miso;
    logic [7:0] miso_cap = 8'd0;
`endif

    int n_checks = 0, n_fail = 0, abort_cnt = 0, pops = 0, lat = 99;
    logic [8:0] sb[$];
    logic ovf_model = 1'b0, prev_abort = 1'b0, rand_ready = 1'b0;

    spi_lcd_receiver #(.FIFO_DEPTH(DEPTH), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .spi_clk(spi_clk), .spi_mosi(spi_mosi),
        .spi_cs_n(spi_cs_n), .lcd_dc(lcd_dc), .rx_data(rx_data), .rx_dc(rx_dc),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_overrun(rx_overrun),
        .overrun_clear(overrun_clear), .rx_abort(rx_abort),
`ifdef SPI_RX_ECHO_EN
        .spi_miso(spi_miso),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: samples 2 ns after the falling clk edge, well away from posedge
    always @(negedge clk) begin
        #2;
        if (!reset) begin
            if (rx_valid && rx_ready) begin
                if (sb.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL pop_unexpected: got 0x%0h, expected no entry", {rx_dc, rx_data});
                end else begin
                    check("pop_data", 32'({rx_dc, rx_data}), 32'(sb.pop_front()));
                    pops++;
                end
            end
            if (!rx_valid) check("empty_outputs_zero", 32'({rx_dc, rx_data}), 32'd0);
            if (rx_abort && prev_abort) check("abort_width", 32'd2, 32'd1);
            if (rx_abort) abort_cnt++;
            prev_abort = rx_abort;
        end
    end

    always @(negedge clk) if (rand_ready) rx_ready = 1'($urandom_range(0, 1));

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic frame_start();
        spi_cs_n = 1'b0; tick(8);
    endtask

    task automatic frame_end();
        spi_cs_n = 1'b1; tick(8);
    endtask

    // 8 clk per spi bit; the model queues the byte on the 8th rising edge
    task automatic send_byte(input logic [7:0] b, input logic dc, input bit pop_with_push);
        lcd_dc = dc;
        for (int i = 7; i >= 0; i--) begin
            spi_mosi = b[i];
            tick(4);
`ifdef SPI_RX_ECHO_EN
            miso_cap = {miso_cap[6:0], spi_miso};
`endif
            spi_clk = 1'b1;
            if (i == 0) begin
                if (sb.size() < DEPTH || pop_with_push) sb.push_back({dc, b});
                else ovf_model = 1'b1;
                lat = 99;
                for (int k = 1; k <= 4; k++) begin
                    tick(1);
                    if (pop_with_push && k == 3) rx_ready = 1'b1;
                    if (pop_with_push && k == 4) rx_ready = 1'b0;
                    if (rx_valid && lat == 99) lat = k;
                end
            end else begin
                tick(4);
            end
            spi_clk = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        tick(4);
        check("reset_outputs", 32'({rx_data, rx_dc, rx_valid, rx_overrun, rx_abort, busy}), 32'd0);
        reset = 1'b0;
        tick(6);

        // Single byte, consumer always ready
        rx_ready = 1'b1;
        p0 = pops;
        frame_start();
        check("busy_in_frame", 32'(busy), 32'd1);
        send_byte(8'hA5, 1'b0, 1'b0);
        check("latency_le_4", 32'(lat <= 4), 32'd1);
        frame_end();
        check("busy_after_frame", 32'(busy), 32'd0);
        check("single_pop", 32'(pops - p0), 32'd1);
        check("no_abort", 32'(abort_cnt), 32'd0);

        // Multi-byte frame, mixed dc, held then drained
        rx_ready = 1'b0;
        frame_start();
        send_byte(8'h2C, 1'b0, 1'b0);
        send_byte(8'h12, 1'b1, 1'b0);
        send_byte(8'h34, 1'b1, 1'b0);
        frame_end();
        check("head_held", 32'({rx_valid, rx_dc, rx_data}), 32'({1'b1, 1'b0, 8'h2C}));
        p0 = pops;
        rx_ready = 1'b1; tick(8); rx_ready = 1'b0;
        check("drain_count", 32'(pops - p0), 32'd3);
        check("drained_empty", 32'(rx_valid), 32'd0);

        // Overrun, clear, then pop coinciding with a new byte on a full FIFO
        frame_start();
        for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b1, 1'b0);
        frame_end();
        check("overrun_set", 32'(rx_overrun), 32'(ovf_model));
        check("full_valid", 32'(rx_valid), 32'd1);
        overrun_clear = 1'b1; tick(1); overrun_clear = 1'b0; ovf_model = 1'b0;
        tick(2);
        check("overrun_cleared", 32'(rx_overrun), 32'd0);
        frame_start();
        send_byte(8'h06, 1'b0, 1'b1);
        frame_end();
        check("no_overrun_on_pop_push", 32'(rx_overrun), 32'(ovf_model));
        rx_ready = 1'b1; tick(10);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        // Partial byte abort, then a clean frame
        p0 = abort_cnt;
        frame_start();
        send_byte(8'hFF, 1'b0, 1'b0) ;
        frame_end();
        check("full_byte_no_abort", 32'(abort_cnt - p0), 32'd0);
        spi_cs_n = 1'b0; tick(8);
        foreach (sb[i]) ;
        for (int i = 0; i < 3; i++) begin
            spi_mosi = (i != 1); tick(4); spi_clk = 1'b1; tick(4); spi_clk = 1'b0;
        end
        frame_end();
        check("abort_pulse", 32'(abort_cnt - p0), 32'd1);
        check("abort_no_push", 32'(rx_valid), 32'd0);
        frame_start();
        send_byte(8'h3C, 1'b0, 1'b0);
        frame_end();

        // Reset mid-byte with an overrun pending
        rx_ready = 1'b0;
        frame_start();
        for (int i = 0; i < 5; i++) send_byte(8'($urandom), 1'($urandom), 1'b0);
        frame_end();
        check("overrun_before_reset", 32'(rx_overrun), 32'(ovf_model));
        spi_cs_n = 1'b0; tick(8);
        for (int i = 0; i < 4; i++) begin
            spi_mosi = 1'b1; tick(4); spi_clk = 1'b1; tick(4); spi_clk = 1'b0;
        end
        reset = 1'b1; tick(2);
        sb.delete(); ovf_model = 1'b0;
        reset = 1'b0; rx_ready = 1'b1;
        check("reset_flush", 32'({rx_valid, rx_overrun}), 32'd0);
        for (int i = 0; i < 4; i++) begin
            spi_mosi = 1'b0; tick(4); spi_clk = 1'b1; tick(4); spi_clk = 1'b0;
        end
        tick(8);
        check("post_reset_no_push", 32'(rx_valid), 32'd0);
        frame_end();
        p0 = pops;
        frame_start();
        send_byte(8'h7E, 1'b1, 1'b0);
        frame_end();
        check("post_reset_byte", 32'(pops - p0), 32'd1);

`ifdef SPI_RX_ECHO_EN
        frame_start(); send_byte(8'h5A, 1'b0, 1'b0); frame_end();
        check("miso_idle", 32'(spi_miso), 32'd0);
        frame_start(); send_byte(8'hC3, 1'b1, 1'b0);
        check("miso_echo", 32'(miso_cap), 32'h5A);
        send_byte(8'h81, 1'b1, 1'b0);
        check("miso_echo_2nd", 32'(miso_cap), 32'hC3);
        frame_end();
`endif

        // Randomized frames with a randomly stalling consumer
        rand_ready = 1'b1;
        for (int f = 0; f < 6; f++) begin
            frame_start();
            for (int b = 0; b < int'($urandom_range(1, 3)); b++)
                send_byte(8'($urandom), 1'($urandom), 1'b0);
            frame_end();
        end
        rand_ready = 1'b0;
        tick(1);
        rx_ready = 1'b1; tick(10);
        check("random_drained", 32'(sb.size()), 32'd0);
        check("random_no_overrun", 32'(rx_overrun), 32'(ovf_model));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
